// File: rtl/mux8way_arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
// Optional grant timeout is enabled by defining MUX8_ARB_TIMEOUT_EN.
package mux8way_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Starting from 7 makes the first search after reset begin at requester 0.
    localparam logic [SEL_W-1:0] LAST_OWNER_RST = 3'd7;

    function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        onehot8 = 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/mux8way_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set bit of req at or above start,
// wrapping 7 -> 0.
module rr_pick8
    import mux8way_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [SEL_W-1:0]     off_s;

    // Rotate so requester 'start' sits at bit 0, priority-encode, then rotate back.
    always_comb begin
        dbl_s = {req, req};
        rot_s = dbl_s[start +: NUM_REQ];
        off_s = 3'd0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            off_s = rot_s[j] ? 3'(j) : off_s;
        end
        found = |req;
        idx   = start + off_s;
    end

endmodule

// File: rtl/mux8way_arbiter.sv
// Round-robin arbiter owning the select of a Mux8Way datapath; all outputs registered.
// Define MUX8_ARB_TIMEOUT_EN to force-release an owner after HOLD_MAX cycles.
module mux8way_arbiter
    import mux8way_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [SEL_W-1:0]   sel,
    output logic               timeout
);

    arb_state_e         state_r;
    arb_state_e         state_nxt_s;
    logic [SEL_W-1:0]   last_owner_r;
    logic [SEL_W-1:0]   last_owner_nxt_s;

    logic [NUM_REQ-1:0] pick_req_s;
    logic [SEL_W-1:0]   pick_start_s;
    logic               pick_found_s;
    logic [SEL_W-1:0]   pick_idx_s;

    logic               owner_req_s;
    logic               force_rel_s;
    logic               release_s;
    logic               take_s;

    logic [NUM_REQ-1:0] grant_nxt_s;
    logic               valid_nxt_s;
    logic [SEL_W-1:0]   sel_nxt_s;
    logic               timeout_nxt_s;

`ifdef MUX8_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_cnt_r;
    logic [7:0] hold_cnt_nxt_s;
`endif

    // Release conditions and the request vector offered to the picker.
    always_comb begin
        owner_req_s = req[last_owner_r];
`ifdef MUX8_ARB_TIMEOUT_EN
        force_rel_s = (state_r == GRANT) && owner_req_s && !done && (hold_cnt_r == HOLD_LAST);
`else
        force_rel_s = 1'b0;
`endif
        release_s    = (state_r == GRANT) && (done || !owner_req_s || force_rel_s);
        // The releasing owner must not win its own release edge.
        pick_req_s   = (state_r == GRANT) ? (req & ~onehot8(last_owner_r)) : req;
        pick_start_s = last_owner_r + 3'd1;
    end

    rr_pick8 u_pick (
        .req   (pick_req_s),
        .start (pick_start_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        take_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s = GRANT;
                    take_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    if (pick_found_s) begin
                        state_nxt_s = GRANT;
                        take_s      = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and owner tracking.
    always_comb begin
        grant_nxt_s      = grant;
        valid_nxt_s      = grant_valid;
        sel_nxt_s        = sel;
        last_owner_nxt_s = last_owner_r;
        timeout_nxt_s    = force_rel_s;
        if (take_s) begin
            grant_nxt_s      = onehot8(pick_idx_s);
            valid_nxt_s      = 1'b1;
            sel_nxt_s        = pick_idx_s;
            last_owner_nxt_s = pick_idx_s;
        end else if (state_nxt_s == IDLE) begin
            grant_nxt_s = 8'b0000_0000;
            valid_nxt_s = 1'b0;
        end else begin
            grant_nxt_s = grant;
        end
    end

`ifdef MUX8_ARB_TIMEOUT_EN
    // Hold counter: zero on a fresh grant, counts while the same owner keeps the path.
    always_comb begin
        if (take_s) begin
            hold_cnt_nxt_s = 8'd0;
        end else if ((state_r == GRANT) && (state_nxt_s == GRANT)) begin
            hold_cnt_nxt_s = hold_cnt_r + 8'd1;
        end else begin
            hold_cnt_nxt_s = 8'd0;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= 8'd0;
        end else begin
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end
`endif

    // State and owner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_owner_r <= LAST_OWNER_RST;
        end else begin
            state_r      <= state_nxt_s;
            last_owner_r <= last_owner_nxt_s;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= 8'b0000_0000;
            grant_valid <= 1'b0;
            sel         <= 3'd0;
            timeout     <= 1'b0;
        end else begin
            grant       <= grant_nxt_s;
            grant_valid <= valid_nxt_s;
            sel         <= sel_nxt_s;
            timeout     <= timeout_nxt_s;
        end
    end

endmodule
